seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have the port sclk, input, 1 bit: the single system clock (100 MHz); all state is clocked on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port scan_clk, input, 1 bit: the divider's 400 Hz square wave, treated as a level signal and never used as a clock.
REQ-004 The block SHALL have the port blink_clk, input, 1 bit: the divider's 2 Hz square wave, treated as a level signal.
REQ-005 The block SHALL have the port digits, input, 16 bits: digit i is digits[4i+3:4i]; digit 3 is the leftmost.
REQ-006 The block SHALL have the port blink_mask, input, 4 bits: bit i = 1 makes digit i blink.
REQ-007 The block SHALL have the port dp_mask, input, 4 bits: bit i = 1 lights the decimal point on digit i.
REQ-008 The block SHALL have the port an, output, 4 bits: anode enables, active-low, one-hot-low or all-high.
REQ-009 The block SHALL have the port seg, output, 7 bits: cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have the port dp, output, 1 bit: decimal-point cathode, active-low.

Function
REQ-011 scan_clk and blink_clk SHALL each pass through a 2-flop synchronizer followed by a history flop; a strobe SHALL assert for exactly one sclk cycle per detected rising edge.
REQ-012 A falling edge or a constant level on scan_clk or blink_clk SHALL produce no strobe.
REQ-013 On each scan strobe, the 2-bit digit index SHALL advance 0->1->2->3->0 and wrap from 3 to 0 with no idle slot.
REQ-014 When the index advances to 0, digits, blink_mask and dp_mask SHALL be captured into snapshot registers; digits 0-3 of one scan frame SHALL all come from the same snapshot.
REQ-015 an, seg and dp SHALL be registered and SHALL update on the same sclk edge that the index updates, computed from the new index.
REQ-016 Total latency SHALL be exactly 3 sclk edges from the first sclk edge that samples scan_clk high to the output change.
REQ-017 seg SHALL decode the 4-bit value as hex 0-F; A-F SHALL use standard forms A, b, C, d, E, F.
REQ-018 Each blink strobe SHALL toggle a blink_phase flop.
REQ-019 While blink_phase = 1 and snapshot blink_mask[index] = 1, an SHALL be 4'b1111, seg 7'h7F and dp 1.
REQ-020 dp SHALL be 0 when snapshot dp_mask[index] = 1 and the digit is not blanked, and 1 otherwise.
REQ-021 When scan and blink strobes occur in the same cycle, both SHALL take effect and the outputs SHALL use the new blink_phase.
REQ-022 Between scan strobes, outputs SHALL hold their value; an SHALL never have more than one bit low.

Reset
REQ-023 While rst_n = 0, the block SHALL immediately force: an = 4'b1111, seg = 7'h7F, dp = 1, index = 3, blink_phase = 0, and synchronizer/history flops, snapshots and strobes all 0.
REQ-024 Because index resets to 3, the first scan strobe after reset release SHALL select digit 0 and take a fresh snapshot.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no partial output retained.

Configuration
REQ-026 With macro SEG_SCAN_LEADING_ZERO_BLANK_EN defined, the block SHALL blank leading zeros: digit 3 when its snapshot is 0, and digit 2 when snapshot digits 3 and 2 are both 0.
REQ-027 Leading-zero blanking SHALL use the same all-off output as REQ-019 and SHALL also suppress dp.
REQ-028 Without SEG_SCAN_LEADING_ZERO_BLANK_EN, all four digits SHALL always be driven, subject only to blink.

Verification
REQ-029 The bench SHALL cover: rst_n = 0 mid-scan -> an = 1111, seg = 7F, dp = 1 before the next sclk edge; after release the first scan edge gives an = 1110.
REQ-030 The bench SHALL cover: digits = 16'h1234, 8 scan_clk rising edges -> an sequence 1110, 1101, 1011, 0111, repeated; seg = 4, 3, 2, 1 patterns (7'h19, 7'h30, 7'h24, 7'h79); each change exactly 3 sclk edges after scan_clk rises.
REQ-031 The bench SHALL cover: digits changed from 16'h1234 to 16'h5678 while index = 1 -> digits 2 and 3 still show 2 and 1; 5678 appears from the next index-0 slot.
REQ-032 The bench SHALL cover: blink_mask = 4'b0001 with one blink_clk rising edge -> the digit-0 slot shows an = 1111, seg = 7F; a second blink edge restores an = 1110.
REQ-033 The bench SHALL cover: scan and blink rising edges in the same sclk cycle, with blink_mask[next index] = 1 -> that slot is blanked on the same update edge.
REQ-034 The bench SHALL cover: digits = 16'h0007, dp_mask = 4'b0100 -> with SEG_SCAN_LEADING_ZERO_BLANK_EN, the digit 3 and 2 slots are all-off (dp = 1); without the macro they show 0, and digit 2 has dp = 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with per-digit blink and decimal point.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_driver (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        scan_clk,
  input  logic        blink_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      4'hF:    pattern = 7'h0E;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  logic [1:0]  scan_sync_q;
  logic        scan_hist_q;
  logic [1:0]  blink_sync_q;
  logic        blink_hist_q;
  logic [1:0]  idx_q,        idx_d;
  logic        phase_q,      phase_d;
  logic [15:0] snap_dig_q,   snap_dig_d;
  logic [3:0]  snap_blink_q, snap_blink_d;
  logic [3:0]  snap_dp_q,    snap_dp_d;
  logic [3:0]  an_q,         an_d;
  logic [6:0]  seg_q,        seg_d;
  logic        dp_q,         dp_d;
  logic        scan_stb_s;
  logic        blink_stb_s;
  logic [3:0]  nib_s;
  logic        blank_s;

  // Rising-edge strobes from the synchronised level inputs
  assign scan_stb_s  = scan_sync_q[1]  & ~scan_hist_q;
  assign blink_stb_s = blink_sync_q[1] & ~blink_hist_q;

  // Synchronizers, edge-history flops and all scan/display state
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_sync_q  <= 2'b00;
      scan_hist_q  <= 1'b0;
      blink_sync_q <= 2'b00;
      blink_hist_q <= 1'b0;
      idx_q        <= 2'd3;
      phase_q      <= 1'b0;
      snap_dig_q   <= 16'h0000;
      snap_blink_q <= 4'h0;
      snap_dp_q    <= 4'h0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      scan_sync_q  <= {scan_sync_q[0], scan_clk};
      scan_hist_q  <= scan_sync_q[1];
      blink_sync_q <= {blink_sync_q[0], blink_clk};
      blink_hist_q <= blink_sync_q[1];
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      snap_dig_q   <= snap_dig_d;
      snap_blink_q <= snap_blink_d;
      snap_dp_q    <= snap_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  // Next index, snapshot, blink phase and outputs; outputs use the post-update state
  always_comb begin
    idx_d        = idx_q;
    snap_dig_d   = snap_dig_q;
    snap_blink_d = snap_blink_q;
    snap_dp_d    = snap_dp_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    nib_s        = 4'h0;
    blank_s      = 1'b0;
    phase_d      = blink_stb_s ? ~phase_q : phase_q;
    if (scan_stb_s) begin
      idx_d = idx_q + 2'd1;
      if (idx_d == 2'd0) begin
        snap_dig_d   = digits;
        snap_blink_d = blink_mask;
        snap_dp_d    = dp_mask;
      end else begin
        snap_dig_d   = snap_dig_q;
      end
      nib_s   = snap_dig_d[{idx_d, 2'b00} +: 4];
      blank_s = phase_d & snap_blink_d[idx_d];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      blank_s = blank_s
              | ((idx_d == 2'd3) & (snap_dig_d[15:12] == 4'h0))
              | ((idx_d == 2'd2) & (snap_dig_d[15:8] == 8'h00));
`endif
      if (blank_s) begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = hex_to_seg(nib_s);
        dp_d  = ~snap_dp_d[idx_d];
      end
    end else begin
      idx_d = idx_q;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a digit-level reference model predicts each scan slot,
// and a monitor checks every output change lands exactly 3 sclk edges after scan_clk rises.
module tb_seg_scan_driver;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        scan_clk = 1'b0;
  logic        blink_clk = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_scan_driver dut (
    .sclk(sclk), .rst_n(rst_n), .scan_clk(scan_clk), .blink_clk(blink_clk),
    .digits(digits), .blink_mask(blink_mask), .dp_mask(dp_mask),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [11:0] outv;
  } exp_t;
  exp_t exp_q[$];

  // reference model state: digit position, blink phase, frame snapshot
  int          m_pos = 3;
  bit          m_phase = 1'b0;
  logic [15:0] m_dig = 16'h0000;
  logic [3:0]  m_bm = 4'h0;
  logic [3:0]  m_dm = 4'h0;
  logic [6:0]  segtab [16];

  initial begin
    segtab[0]  = 7'h40; segtab[1]  = 7'h79; segtab[2]  = 7'h24; segtab[3]  = 7'h30;
    segtab[4]  = 7'h19; segtab[5]  = 7'h12; segtab[6]  = 7'h02; segtab[7]  = 7'h78;
    segtab[8]  = 7'h00; segtab[9]  = 7'h10; segtab[10] = 7'h08; segtab[11] = 7'h03;
    segtab[12] = 7'h46; segtab[13] = 7'h21; segtab[14] = 7'h06; segtab[15] = 7'h0E;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b (cycle %0d)",
               name, act[11:8], act[7:1], act[0], req[11:8], req[7:1], req[0], cyc);
    end
  endtask

  task automatic model_scan(input bit with_blink);
    int   nib;
    bit   blank;
    exp_t e;
    if (with_blink) m_phase = !m_phase;
    m_pos = (m_pos + 1) % 4;
    if (m_pos == 0) begin
      m_dig = digits; m_bm = blink_mask; m_dm = dp_mask;
    end
    nib   = (int'(m_dig) >> (4 * m_pos)) % 16;
    blank = m_phase && m_bm[m_pos];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (m_pos == 3 && m_dig / 4096 == 0) blank = 1'b1;
    if (m_pos == 2 && m_dig / 256 == 0) blank = 1'b1;
`endif
    e.due = cyc + 3;
    if (blank) e.outv = {4'b1111, 7'h7F, 1'b1};
    else       e.outv = {4'(15 - (1 << m_pos)), segtab[nib], !m_dm[m_pos]};
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic scan_pulse(input bit with_blink);
    @(negedge sclk);
    scan_clk = 1'b1;
    if (with_blink) blink_clk = 1'b1;
    model_scan(with_blink);
    wait_cyc(6);
    scan_clk = 1'b0;
    blink_clk = 1'b0;
    wait_cyc(6);
  endtask

  task automatic blink_edge();
    @(negedge sclk);
    blink_clk = 1'b1;
    m_phase = !m_phase;
    wait_cyc(6);
    blink_clk = 1'b0;
    wait_cyc(6);
  endtask

  // Monitor: pops expectations when due, otherwise outputs must hold
  logic [11:0] prev_out = 12'hFFF;
  always @(negedge sclk) begin
    bit matched;
    exp_t e;
    matched = 1'b0;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        total++;
        if (e.due != cyc) begin
          bad++;
          $display("FAIL latency: expectation due at cycle %0d not seen, now %0d", e.due, cyc);
        end
        check("slot", {an, seg, dp}, e.outv);
        matched = 1'b1;
      end
      if (!matched) check("hold", {an, seg, dp}, prev_out);
      total++;
      if ($countones(~an) > 1) begin
        bad++;
        $display("FAIL onehot: an=%b, required at most one low bit", an);
      end
    end
    prev_out = {an, seg, dp};
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check("reset_init", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);

    // 1234 over two frames, then swap digits mid-frame at position 1
    digits = 16'h1234;
    for (int i = 0; i < 8; i++) scan_pulse(1'b0);
    scan_pulse(1'b0);
    scan_pulse(1'b0);
    digits = 16'h5678;
    for (int i = 0; i < 4; i++) scan_pulse(1'b0);

    // blink digit 0 on, then off
    blink_mask = 4'b0001;
    blink_edge();
    for (int i = 0; i < 4; i++) scan_pulse(1'b0);
    blink_edge();
    for (int i = 0; i < 4; i++) scan_pulse(1'b0);

    // scan and blink rising together: blinking slot is blanked on that same update
    for (int i = 0; i < 4; i++) begin
      blink_mask = 4'hF;
      scan_pulse(1'b1);
    end
    blink_mask = 4'h0;
    for (int i = 0; i < 4; i++) scan_pulse(1'b0);
    if (m_phase) blink_edge();

    // reset asserted while a scan edge is in flight
    @(negedge sclk);
    scan_clk = 1'b1;
    wait_cyc(1);
    #2 rst_n = 1'b0;
    #1 check("reset_mid", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
    scan_clk = 1'b0;
    exp_q.delete();
    m_pos = 3;
    m_phase = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    scan_pulse(1'b0);
    total++;
    if (an !== 4'b1110) begin
      bad++;
      $display("FAIL first_after_reset: an=%b, required 1110", an);
    end

    // leading-zero case
    digits = 16'h0007;
    dp_mask = 4'b0100;
    for (int i = 0; i < 8; i++) scan_pulse(1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 3) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 3) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) blink_edge();
      scan_pulse($urandom_range(0, 4) == 0);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) wait_cyc(1);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never checked", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
